// File: rtl/native_port_pkg.sv
// native_port_pkg: shared definitions for the native video port path.
// Holds the packing-mode encodings, the default pixel/slot/word widths and
// the packed tag type that travels with every word written to the FIFO.
package native_port_pkg;
    localparam logic [31:0] MODE_ONCE = "ONCE";
    localparam logic [31:0] MODE_LINE = "LINE";
    localparam int DSIZE_DEF = 24;
    localparam int PSIZE_DEF = 32;
    localparam int MSIZE_DEF = 256;
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } wr_tag_t;
endpackage

// File: rtl/native_in_pack_if.sv
// native_in_pack_if: video-side and FIFO-side signals of the write packer.
// Video side: vactive/hactive frame size, falign/lalign/ealign alignment
// pulses, idata_vld/idata pixel stream, wr_full FIFO status.
// FIFO side: wr_en strobe, wr_data word, wr_sof/wr_eol/wr_eof tags and the
// sticky overflow/len_err flags.
// master = stimulus/port side, slave = the packer.
interface native_in_pack_if #(
    parameter int DSIZE = native_port_pkg::DSIZE_DEF,
    parameter int MSIZE = native_port_pkg::MSIZE_DEF
);
    logic [15:0]      vactive;
    logic [15:0]      hactive;
    logic             falign;
    logic             lalign;
    logic             ealign;
    logic             idata_vld;
    logic [DSIZE-1:0] idata;
    logic             wr_full;
    logic             wr_en;
    logic [MSIZE-1:0] wr_data;
    logic             wr_sof;
    logic             wr_eol;
    logic             wr_eof;
    logic             overflow;
    logic             len_err;

    modport master (
        output vactive, hactive, falign, lalign, ealign, idata_vld, idata, wr_full,
        input  wr_en, wr_data, wr_sof, wr_eol, wr_eof, overflow, len_err
    );

    modport slave (
        input  vactive, hactive, falign, lalign, ealign, idata_vld, idata, wr_full,
        output wr_en, wr_data, wr_sof, wr_eol, wr_eof, overflow, len_err
    );
endinterface

// File: rtl/pack_word_asm.sv
// pack_word_asm: slot pointer plus word assembly register.
// Ports: clock/rst (async, active-high); clear_i drops the partial word and
// restarts at slot 0 (takes effect before a same-cycle load); load_i places
// pix_i into the current slot; close_i empties the word after this cycle.
// slot_o is the slot the current pixel lands in, word_o the word including
// that pixel, busy_o flags a non-empty partial word.
module pack_word_asm #(
    parameter int DSIZE = 24,
    parameter int PSIZE = 32,
    parameter int MSIZE = 256
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             close_i,
    input  logic [DSIZE-1:0] pix_i,
    output logic [$clog2(MSIZE/PSIZE)-1:0] slot_o,
    output logic [MSIZE-1:0] word_o,
    output logic             busy_o
);
    localparam int SW = $clog2(MSIZE / PSIZE);

    logic [SW-1:0]    slot_q, slot_d;
    logic [MSIZE-1:0] word_q, word_d;
    int               base;

    assign slot_o = clear_i ? '0 : slot_q;
    // The slot pointer only returns to 0 on a close, so a non-zero pointer
    // is exactly "something is waiting in the word".
    assign busy_o = slot_q != '0;

    always_comb begin
        base = int'(slot_o) * PSIZE;
        word_o = clear_i ? '0 : word_q;
        if (load_i) word_o[base +: DSIZE] = pix_i;
        slot_d = close_i ? '0 : load_i ? slot_o + 1'b1 : slot_o;
        word_d = close_i ? '0 : word_o;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            word_q <= '0;
        end else begin
            slot_q <= slot_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/native_in_pack.sv
// native_in_pack: packs native-port pixels into MSIZE-bit FIFO words.
// Ports: clock, rst (async, active-high) and bus (slave side of
// native_in_pack_if): frame size, alignment pulses and pixel stream in;
// wr_en/wr_data/wr_sof/wr_eol/wr_eof FIFO write and sticky overflow/len_err
// out. Video cannot stall, so a full FIFO drops the word and raises overflow.
module native_in_pack import native_port_pkg::*; #(
    parameter int          DSIZE = DSIZE_DEF,
    parameter int          PSIZE = PSIZE_DEF,
    parameter int          MSIZE = MSIZE_DEF,
    parameter logic [31:0] MODE  = MODE_ONCE
) (
    input logic             clock,
    input logic             rst,
    native_in_pack_if.slave bus
);
    localparam int NUM  = MSIZE / PSIZE;
    localparam int SW   = $clog2(NUM);
    localparam bit LINE = MODE == MODE_LINE;

    if (PSIZE < DSIZE) begin : g_bad_psize
        $error("native_in_pack: PSIZE must be >= DSIZE");
    end
    if (MSIZE % PSIZE != 0) begin : g_bad_msize
        $error("native_in_pack: MSIZE must be a multiple of PSIZE");
    end
    if (NUM < 2) begin : g_bad_num
        $error("native_in_pack: need at least two slots per word");
    end

    logic [15:0]      hact_q, hact_d, vact_q, vact_d;
    logic [15:0]      pcnt_q, pcnt_d, lcnt_q, lcnt_d;
    logic             sof_arm_q, sof_arm_d, fd_q, fd_d;
    logic             wr_en_q, wr_en_d, ovf_q, ovf_d, lerr_q, lerr_d;
    logic [MSIZE-1:0] wr_data_q, wr_data_d;
    wr_tag_t          tag_q, tag_d;

    logic [SW-1:0]    slot;
    logic [MSIZE-1:0] word;
    logic             busy;

    logic             fd_eff, sof_eff, acc, eol_px, eof_px, close_px;
    logic             fd_post, busy_post, ef, lf, close;
    logic [15:0]      pcnt_eff, lcnt_eff, pcnt_post;

    pack_word_asm #(.DSIZE(DSIZE), .PSIZE(PSIZE), .MSIZE(MSIZE)) u_asm (
        .clock   (clock),
        .rst     (rst),
        .clear_i (bus.falign),
        .load_i  (acc),
        .close_i (close),
        .pix_i   (bus.idata),
        .slot_o  (slot),
        .word_o  (word),
        .busy_o  (busy)
    );

    // Each cycle is evaluated in priority order: falign first re-bases the
    // frame (the *_eff values), then the pixel (the *_post values), then an
    // ealign or lalign flush acting on what the pixel left behind.
    always_comb begin
        hact_d    = bus.falign ? bus.hactive : hact_q;
        vact_d    = bus.falign ? bus.vactive : vact_q;
        fd_eff    = bus.falign ? (bus.hactive == '0 || bus.vactive == '0) : fd_q;
        pcnt_eff  = bus.falign ? '0 : pcnt_q;
        lcnt_eff  = bus.falign ? '0 : lcnt_q;
        sof_eff   = bus.falign | sof_arm_q;
        acc       = bus.idata_vld && !fd_eff;
        eol_px    = acc && pcnt_eff == hact_d - 16'd1;
        eof_px    = eol_px && lcnt_eff == vact_d - 16'd1;
        close_px  = acc && (slot == SW'(NUM - 1) || eof_px || (LINE && eol_px));
        pcnt_post = eol_px ? '0 : pcnt_eff + 16'(acc);
        fd_post   = fd_eff || eof_px;
        busy_post = acc ? !close_px : busy && !bus.falign;
        ef        = !bus.falign && bus.ealign && !fd_post;
        lf        = !bus.falign && !ef && bus.lalign && pcnt_post != '0;
        // A flush only writes when a partial word is left; if the pixel
        // already closed a word this cycle, that word carries the flush tag.
        close     = close_px || ((ef || (LINE && lf)) && busy_post);
        pcnt_d    = lf ? '0 : pcnt_post;
        lcnt_d    = lcnt_eff + 16'(eol_px) + 16'(lf);
        fd_d      = fd_post || ef;
        sof_arm_d = sof_eff && !close;
        wr_en_d   = close && !bus.wr_full;
        wr_data_d = wr_en_d ? word : '0;
        tag_d.sof = wr_en_d && sof_eff;
        tag_d.eol = wr_en_d && LINE && (eol_px || lf);
        tag_d.eof = wr_en_d && (eof_px || ef);
        ovf_d     = ovf_q || (close && bus.wr_full);
        lerr_d    = lerr_q || (bus.falign && busy) || (!bus.falign && bus.idata_vld && fd_q) || ef || lf;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hact_q    <= '0;
            vact_q    <= '0;
            pcnt_q    <= '0;
            lcnt_q    <= '0;
            sof_arm_q <= 1'b0;
            fd_q      <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            tag_q     <= '0;
            ovf_q     <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            hact_q    <= hact_d;
            vact_q    <= vact_d;
            pcnt_q    <= pcnt_d;
            lcnt_q    <= lcnt_d;
            sof_arm_q <= sof_arm_d;
            fd_q      <= fd_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            tag_q     <= tag_d;
            ovf_q     <= ovf_d;
            lerr_q    <= lerr_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_sof   = tag_q.sof;
    assign bus.wr_eol   = tag_q.eol;
    assign bus.wr_eof   = tag_q.eof;
    assign bus.overflow = ovf_q;
    assign bus.len_err  = lerr_q;
endmodule

// File: tb/tb_native_in_pack.sv
// tb_native_in_pack: drives a LINE-mode and a ONCE-mode packer with the same
// stimulus and checks both against a pixel-queue reference model.
module tb_native_in_pack;
    import native_port_pkg::*;
    localparam int NUM = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        falign, lalign, ealign, vld, full;
    logic [23:0] pix;
    logic [15:0] hin, vin;
    int          checks = 0;
    int          fails = 0;

    native_in_pack_if bl();
    native_in_pack_if bo();

    assign bl.falign = falign;    assign bo.falign = falign;
    assign bl.lalign = lalign;    assign bo.lalign = lalign;
    assign bl.ealign = ealign;    assign bo.ealign = ealign;
    assign bl.idata_vld = vld;    assign bo.idata_vld = vld;
    assign bl.idata = pix;        assign bo.idata = pix;
    assign bl.wr_full = full;     assign bo.wr_full = full;
    assign bl.hactive = hin;      assign bo.hactive = hin;
    assign bl.vactive = vin;      assign bo.vactive = vin;

    native_in_pack #(.MODE(MODE_LINE)) dut_line (.clock(clk), .rst(rst), .bus(bl));
    native_in_pack #(.MODE(MODE_ONCE)) dut_once (.clock(clk), .rst(rst), .bus(bo));

    // Reference model, index 0 = LINE, 1 = ONCE. A word is a queue of pixels.
    logic [23:0]  mq[2][$];
    int           m_pcnt[2], m_lcnt[2], m_hact[2], m_vact[2];
    bit           m_sof[2], m_fd[2], m_ovf[2], m_lerr[2];
    // {en, data[255:0], sof, eol, eof, overflow, len_err}
    logic [261:0] exp_v[2];

    function automatic logic [261:0] obs(int m);
        logic en, s, l, e, o, r;
        logic [255:0] d;
        if (m == 0) {en, d, s, l, e, o, r} = {bl.wr_en, bl.wr_data, bl.wr_sof, bl.wr_eol, bl.wr_eof, bl.overflow, bl.len_err};
        else        {en, d, s, l, e, o, r} = {bo.wr_en, bo.wr_data, bo.wr_sof, bo.wr_eol, bo.wr_eof, bo.overflow, bo.len_err};
        return {en, en ? d : 256'd0, en & s, en & l, en & e, o, r};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            m_pcnt[m] = 0; m_lcnt[m] = 0; m_hact[m] = 0; m_vact[m] = 0;
            m_sof[m] = 0; m_fd[m] = 1; m_ovf[m] = 0; m_lerr[m] = 0;
            exp_v[m] = '0;
        end
    endtask

    task automatic model_step(int m);
        bit line = (m == 0);
        bit close = 0, eol = 0, eof = 0;
        logic [255:0] d = '0;
        if (falign) begin
            if (mq[m].size() != 0) m_lerr[m] = 1;
            mq[m].delete();
            m_hact[m] = hin; m_vact[m] = vin; m_pcnt[m] = 0; m_lcnt[m] = 0;
            m_sof[m] = 1; m_fd[m] = (hin == 0 || vin == 0);
        end
        if (vld && m_fd[m] && !falign) m_lerr[m] = 1;
        if (vld && !m_fd[m]) begin
            mq[m].push_back(pix);
            m_pcnt[m]++;
            if (mq[m].size() == NUM) close = 1;
            if (m_pcnt[m] == m_hact[m]) begin
                m_pcnt[m] = 0;
                m_lcnt[m]++;
                if (line) begin close = 1; eol = 1; end
                if (m_lcnt[m] == m_vact[m]) begin m_fd[m] = 1; close = 1; eof = 1; end
            end
        end
        if (!falign && ealign && !m_fd[m]) begin
            m_lerr[m] = 1; m_fd[m] = 1; eof = 1;
            if (mq[m].size() != 0) close = 1;
        end else if (!falign && lalign && m_pcnt[m] != 0) begin
            m_lerr[m] = 1; m_pcnt[m] = 0; m_lcnt[m]++;
            if (line) begin eol = 1; if (mq[m].size() != 0) close = 1; end
        end
        exp_v[m] = '0;
        if (close) begin
            if (full) m_ovf[m] = 1;
            else begin
                for (int i = 0; i < mq[m].size(); i++) d[i*32 +: 24] = mq[m][i];
                exp_v[m][261] = 1'b1;
                exp_v[m][260:5] = d;
                exp_v[m][4:2] = {m_sof[m], eol, eof};
            end
            m_sof[m] = 0;
            mq[m].delete();
        end
        exp_v[m][1] = m_ovf[m];
        exp_v[m][0] = m_lerr[m];
    endtask

    task automatic idle();
        falign = 0; lalign = 0; ealign = 0; vld = 0; full = 0;
    endtask

    task automatic cyc();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        hin = 0; vin = 0; pix = 0;
        rst = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== 262'd0) begin fails++; $display("FAIL reset m=%0d got=%h exp=0", m, obs(m)); end
        end
        rst = 0;
        cyc();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== exp_v[m]) begin fails++; $display("FAIL reset_idle m=%0d got=%h exp=%h", m, obs(m), exp_v[m]); end
        end
    endtask

    task automatic test_line_frame();
        int nl = 0, no = 0;
        logic [3:0] ls = 0, le = 0, lf = 0;
        logic [2:0] os = 0, oe = 0, of = 0;
        logic [255:0] w1 = '0;
        idle();
        hin = 10; vin = 2; falign = 1;
        cyc();
        falign = 0;
        for (int i = 0; i < 20; i++) begin
            vld = 1; pix = 24'(i);
            cyc();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_v[m]) begin fails++; $display("FAIL frame m=%0d px=%0d got=%h exp=%h", m, i, obs(m), exp_v[m]); end
            end
            if (bl.wr_en && nl < 4) begin
                ls[nl] = bl.wr_sof; le[nl] = bl.wr_eol; lf[nl] = bl.wr_eof;
                if (nl == 1) w1 = bl.wr_data;
            end
            if (bo.wr_en && no < 3) begin os[no] = bo.wr_sof; oe[no] = bo.wr_eol; of[no] = bo.wr_eof; end
            nl += int'(bl.wr_en); no += int'(bo.wr_en);
        end
        vld = 0;
        checks++;
        if (nl != 4 || no != 3) begin fails++; $display("FAIL frame_writes got line=%0d once=%0d exp line=4 once=3", nl, no); end
        checks++;
        if ({ls, le, lf} !== 12'b0001_1010_1000) begin fails++; $display("FAIL line_tags got sof=%b eol=%b eof=%b exp 0001 1010 1000", ls, le, lf); end
        checks++;
        if ({os, oe, of} !== 9'b001_000_100) begin fails++; $display("FAIL once_tags got sof=%b eol=%b eof=%b exp 001 000 100", os, oe, of); end
        checks++;
        if (w1 !== 256'h0000000900000008) begin fails++; $display("FAIL line_word1 got=%h exp=0000000900000008", w1); end
        checks++;
        if (bl.len_err !== 1'b0 || bo.len_err !== 1'b0) begin fails++; $display("FAIL frame_len_err got %b%b exp 00", bl.len_err, bo.len_err); end
    endtask

    task automatic test_slot_layout();
        idle();
        hin = 4; vin = 1; falign = 1;
        cyc();
        falign = 0;
        for (int i = 0; i < 4; i++) begin
            vld = 1; pix = (i == 3) ? 24'h123456 : 24'(i + 1);
            cyc();
        end
        vld = 0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== exp_v[m]) begin fails++; $display("FAIL layout_model m=%0d got=%h exp=%h", m, obs(m), exp_v[m]); end
        end
        checks++;
        if (bl.wr_en !== 1'b1 || bl.wr_data[127:96] !== 32'h00123456 || bl.wr_data[255:128] !== '0 || bl.wr_eof !== 1'b1)
            begin fails++; $display("FAIL layout_line got en=%b data=%h exp slot3=00123456", bl.wr_en, bl.wr_data); end
        checks++;
        if (bo.wr_en !== 1'b1 || bo.wr_data[127:96] !== 32'h00123456 || bo.wr_data[255:128] !== '0)
            begin fails++; $display("FAIL layout_once got en=%b data=%h exp slot3=00123456", bo.wr_en, bo.wr_data); end
    endtask

    task automatic test_short_line();
        logic [255:0] d = '0;
        idle();
        hin = 10; vin = 4; falign = 1;
        cyc();
        falign = 0;
        for (int i = 0; i < 6; i++) begin
            vld = 1; pix = 24'(100 + i); d[i*32 +: 24] = 24'(100 + i);
            cyc();
        end
        vld = 0; lalign = 1;
        cyc();
        lalign = 0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== exp_v[m]) begin fails++; $display("FAIL short_model m=%0d got=%h exp=%h", m, obs(m), exp_v[m]); end
        end
        checks++;
        if ({bl.wr_en, bl.wr_eol, bl.len_err} !== 3'b111 || bl.wr_data !== d)
            begin fails++; $display("FAIL short_line got en/eol/err=%b%b%b data=%h exp 111 %h", bl.wr_en, bl.wr_eol, bl.len_err, bl.wr_data, d); end
        checks++;
        if ({bo.wr_en, bo.len_err} !== 2'b01) begin fails++; $display("FAIL short_once got en/err=%b%b exp 01", bo.wr_en, bo.len_err); end
    endtask

    task automatic test_overflow();
        idle();
        hin = 10; vin = 3; falign = 1;
        cyc();
        falign = 0;
        for (int i = 0; i < 30; i++) begin
            vld = 1; pix = 24'(200 + i); full = (i == 15);
            cyc();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_v[m]) begin fails++; $display("FAIL ovf_model m=%0d px=%0d got=%h exp=%h", m, i, obs(m), exp_v[m]); end
            end
            if (i == 15) begin
                checks++;
                if ({bo.wr_en, bo.overflow, bl.overflow} !== 3'b010) begin fails++; $display("FAIL ovf_drop got en/ovf/line_ovf=%b%b%b exp 010", bo.wr_en, bo.overflow, bl.overflow); end
            end
            if (i == 23) begin
                checks++;
                if ({bo.wr_en, bo.wr_sof} !== 2'b10) begin fails++; $display("FAIL ovf_third got en/sof=%b%b exp 10", bo.wr_en, bo.wr_sof); end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        hin = 10; vin = 2; falign = 1;
        cyc();
        falign = 0;
        for (int i = 0; i < 5; i++) begin vld = 1; pix = 24'(i); cyc(); end
        rst = 1;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== 262'd0) begin fails++; $display("FAIL rst_mid m=%0d got=%h exp=0", m, obs(m)); end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bl.wr_en !== 1'b0 || bo.wr_en !== 1'b0) begin fails++; $display("FAIL rst_hold got en=%b%b exp 00", bl.wr_en, bo.wr_en); end
        rst = 0; vld = 0; falign = 1;
        cyc();
        falign = 0;
        for (int i = 0; i < 8; i++) begin vld = 1; pix = 24'(300 + i); cyc(); end
        vld = 0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== exp_v[m]) begin fails++; $display("FAIL rst_model m=%0d got=%h exp=%h", m, obs(m), exp_v[m]); end
        end
        checks++;
        if ({bl.wr_en, bl.wr_sof, bo.wr_en, bo.wr_sof, bl.len_err, bo.len_err} !== 6'b111100 ||
            bo.wr_data[31:0] !== 32'd300 || bo.wr_data[255:224] !== 32'd307)
            begin fails++; $display("FAIL rst_restart got line en/sof=%b%b once en/sof=%b%b err=%b%b data=%h", bl.wr_en, bl.wr_sof, bo.wr_en, bo.wr_sof, bl.len_err, bo.len_err, bo.wr_data); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            falign = (m_fd[0] && m_fd[1] && $urandom_range(0, 4) == 0) || $urandom_range(0, 199) == 0;
            hin = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            vin = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
            lalign = $urandom_range(0, 29) == 0;
            ealign = $urandom_range(0, 49) == 0;
            vld = $urandom_range(0, 9) < 8;
            full = $urandom_range(0, 9) == 0;
            pix = 24'($urandom);
            cyc();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_v[m]) begin fails++; $display("FAIL random m=%0d cyc=%0d got=%h exp=%h", m, c, obs(m), exp_v[m]); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_line_frame();
        test_slot_layout();
        test_short_line();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
